// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x-oversampled start/data/parity/stop recovery with
// a 3-sample mid-bit majority vote and a one-clk valid pulse per frame.
module uart_rx_frame #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_VALID
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_V0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_V1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic [1:0]             vote_q, vote_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   perror_q, perror_d;
    logic                   ferror_q, ferror_d;
    logic                   valid_q, valid_d;

    logic                   rxd_s;
    logic [TW-1:0]          tick;
    logic                   voted;

    assign rxd_s = sync_q[1];
    // The detecting strobe is tick 0; every later strobe advances to tcnt+1.
    assign tick  = tcnt_q + 1'b1;
    assign voted = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        vote_d   = vote_q;
        data_d   = data_q;
        perror_d = perror_q;
        ferror_d = ferror_q;
        valid_d  = 1'b0;

        if (!Rx_EN) begin
            state_d = IDLE;
            tcnt_d  = '0;
            idx_d   = '0;
        end else if (sample_ENABLE) begin
            if (state_q == IDLE) begin
                if (!rxd_s) begin
                    state_d = START;
                    tcnt_d  = '0;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                end
            end else begin
                tcnt_d = tick;
                if (tick == T_V0) vote_d[0] = rxd_s;
                if (tick == T_V1) vote_d[1] = rxd_s;

                case (state_q)
                    START: begin
                        if (tick == T_DEC && voted) begin
                            state_d = IDLE;
                            tcnt_d  = '0;
                        end else if (tick == '0) begin
                            state_d = DATA;
                            idx_d   = '0;
                        end
                    end
                    DATA: begin
                        if (tick == T_DEC) begin
                            for (int unsigned i = 0; i < DATA_BITS; i++) begin
                                if (idx_q == IW'(i)) shift_d[i] = voted;
                            end
                        end
                        if (tick == '0) begin
                            if (idx_q == I_LAST) begin
                                state_d = (PARITY_EN != 0) ? PARITY : STOP;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick == T_DEC && (voted != ^shift_q)) perr_d = 1'b1;
                        if (tick == '0) state_d = STOP;
                    end
                    STOP: begin
                        // Complete at mid-bit so a short stop bit still lets the next start be seen.
                        if (tick == T_DEC) begin
                            data_d   = shift_q;
                            perror_d = perr_q;
                            ferror_d = ~voted;
                            valid_d  = 1'b1;
                            state_d  = IDLE;
                            tcnt_d   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            state_q  <= IDLE;
            tcnt_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            vote_q   <= '1;
            data_q   <= '0;
            perror_q <= 1'b0;
            ferror_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], RxD};
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            vote_q   <= vote_d;
            data_q   <= data_d;
            perror_q <= perror_d;
            ferror_q <= ferror_d;
            valid_q  <= valid_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_PERROR = perror_q;
    assign Rx_FERROR = ferror_q;
    assign Rx_VALID  = valid_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: one strobe every 4 clk, 16 strobes per bit,
// hand-computed bytes/parity, pulse counting via a negedge monitor.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_VALID;

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int pulse_idx = -1;
    int base = 0;
    logic [7:0] cap [0:63];

    uart_rx_frame #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_ENABLE(sample_ENABLE),
        .Rx_EN        (Rx_EN),
        .RxD          (RxD),
        .Rx_DATA      (Rx_DATA),
        .Rx_PERROR    (Rx_PERROR),
        .Rx_FERROR    (Rx_FERROR),
        .Rx_VALID     (Rx_VALID)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Rx_VALID) begin
            if (vcnt < 64) cap[vcnt] = Rx_DATA;
            vcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe: high for one clk, then three quiet clks; v = Rx_VALID in the clk after it.
    task automatic strobe(output logic v);
        sample_ENABLE = 1'b1;
        @(negedge clk);
        sample_ENABLE = 1'b0;
        v = Rx_VALID;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n, input int glitch_at);
        logic v;
        pulse_idx = -1;
        for (int i = 0; i < n; i++) begin
            RxD = (i == glitch_at) ? ~b : b;
            strobe(v);
            if (v && pulse_idx < 0) pulse_idx = i;
        end
        RxD = b;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int stop_len, input int glitch_bit);
        send_bit(1'b0, 16, -1);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16, (i == glitch_bit) ? 8 : -1);
        send_bit(par, 16, -1);
        send_bit(stp, stop_len, -1);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n, -1);
    endtask

    initial begin
        logic [7:0] d7e;
        d7e = 8'h7E;

        repeat (3) @(negedge clk);
        chk("rst_data", 32'(Rx_DATA), 32'h00);
        chk("rst_perr", 32'(Rx_PERROR), 32'h0);
        chk("rst_ferr", 32'(Rx_FERROR), 32'h0);
        chk("rst_valid", 32'(Rx_VALID), 32'h0);
        reset = 1'b0;
        Rx_EN = 1'b1;
        idle(4);

        // 0x55: four ones, even parity 0. Start is detected on bench strobe 1, so
        // DUT tick 9 of the stop bit is bench strobe 10 of that bit.
        base = vcnt;
        send_frame(8'h55, 1'b0, 1'b1, 16, -1);
        chk("t1_pulse_strobe", 32'(pulse_idx), 32'd10);
        idle(16);
        chk("t1_count", 32'(vcnt - base), 32'd1);
        chk("t1_data", 32'(Rx_DATA), 32'h55);
        chk("t1_perr", 32'(Rx_PERROR), 32'h0);
        chk("t1_ferr", 32'(Rx_FERROR), 32'h0);

        // 0x01 needs parity 1; sending 0 is a parity error.
        base = vcnt;
        send_frame(8'h01, 1'b0, 1'b1, 16, -1);
        idle(16);
        chk("t2_count", 32'(vcnt - base), 32'd1);
        chk("t2_data", 32'(Rx_DATA), 32'h01);
        chk("t2_perr", 32'(Rx_PERROR), 32'h1);
        chk("t2_ferr", 32'(Rx_FERROR), 32'h0);

        // 0xA3 (four ones) with a low stop bit; line returns high soon after the vote.
        base = vcnt;
        send_frame(8'hA3, 1'b0, 1'b0, 11, -1);
        idle(16);
        chk("t3_count", 32'(vcnt - base), 32'd1);
        chk("t3_data", 32'(Rx_DATA), 32'hA3);
        chk("t3_ferr", 32'(Rx_FERROR), 32'h1);
        chk("t3_perr", 32'(Rx_PERROR), 32'h0);
        base = vcnt;
        send_frame(8'h3C, 1'b0, 1'b1, 16, -1);
        idle(16);
        chk("t3b_count", 32'(vcnt - base), 32'd1);
        chk("t3b_data", 32'(Rx_DATA), 32'h3C);
        chk("t3b_ferr", 32'(Rx_FERROR), 32'h0);

        // False start: 5 strobes low.
        base = vcnt;
        send_bit(1'b0, 5, -1);
        idle(20);
        chk("t4_false_count", 32'(vcnt - base), 32'd0);
        chk("t4_false_data", 32'(Rx_DATA), 32'h3C);
        // 0x5A with a one-strobe high glitch on data bit 2 (a 0) at tick 8.
        base = vcnt;
        send_frame(8'h5A, 1'b0, 1'b1, 16, 2);
        idle(16);
        chk("t4_glitch_count", 32'(vcnt - base), 32'd1);
        chk("t4_glitch_data", 32'(Rx_DATA), 32'h5A);
        chk("t4_glitch_perr", 32'(Rx_PERROR), 32'h0);

        // Abort 0x7E during data bit 4.
        base = vcnt;
        send_bit(1'b0, 16, -1);
        for (int i = 0; i < 4; i++) send_bit(d7e[i], 16, -1);
        send_bit(d7e[4], 5, -1);
        Rx_EN = 1'b0;
        idle(20);
        Rx_EN = 1'b1;
        idle(4);
        chk("t5_abort_count", 32'(vcnt - base), 32'd0);
        chk("t5_abort_data", 32'(Rx_DATA), 32'h5A);
        send_frame(8'h81, 1'b0, 1'b1, 16, -1);
        idle(16);
        chk("t5_count", 32'(vcnt - base), 32'd1);
        chk("t5_data", 32'(Rx_DATA), 32'h81);

        // Reset in the middle of the parity bit of 0x12.
        base = vcnt;
        send_bit(1'b0, 16, -1);
        for (int i = 0; i < 8; i++) send_bit(((8'h12 >> i) & 8'h01) != 0, 16, -1);
        send_bit(1'b0, 5, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_data", 32'(Rx_DATA), 32'h00);
        chk("t6_rst_perr", 32'(Rx_PERROR), 32'h0);
        chk("t6_rst_ferr", 32'(Rx_FERROR), 32'h0);
        chk("t6_rst_valid", 32'(Rx_VALID), 32'h0);
        idle(20);
        chk("t6_rst_count", 32'(vcnt - base), 32'd0);

        // Back-to-back 0x12 (parity 0) and 0x34 (parity 1), 10-strobe stop bits.
        base = vcnt;
        send_frame(8'h12, 1'b0, 1'b1, 10, -1);
        send_frame(8'h34, 1'b1, 1'b1, 10, -1);
        idle(16);
        chk("t6_b2b_count", 32'(vcnt - base), 32'd2);
        chk("t6_b2b_first", 32'(cap[base]), 32'h12);
        chk("t6_b2b_second", 32'(cap[base + 1]), 32'h34);
        chk("t6_b2b_perr", 32'(Rx_PERROR), 32'h0);
        chk("t6_b2b_ferr", 32'(Rx_FERROR), 32'h0);

        // Break: line low through the stop vote, released right after.
        base = vcnt;
        send_frame(8'h00, 1'b0, 1'b0, 11, -1);
        idle(20);
        chk("t7_break_count", 32'(vcnt - base), 32'd1);
        chk("t7_break_data", 32'(Rx_DATA), 32'h00);
        chk("t7_break_ferr", 32'(Rx_FERROR), 32'h1);
        chk("t7_break_perr", 32'(Rx_PERROR), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
